// File: rtl/charge_session_if.sv
// Panel-to-sequencer bundle: single-cycle panel pulses in, registered session status out.
interface charge_session_if;
  logic       power_on;
  logic       power_off;
  logic       card_in;
  logic       key_one;
  logic       key_ten;
  logic       key_start;
  logic       key_cancel;
  logic [2:0] state;
  logic       work;
  logic       hold_in;
  logic [1:0] mode;
  logic [4:0] amount;
  logic [7:0] remaining;
  logic       charging;
  logic       done_pulse;

  modport master (
    output power_on, power_off, card_in, key_one, key_ten, key_start, key_cancel,
    input  state, work, hold_in, mode, amount, remaining, charging, done_pulse
  );

  modport slave (
    input  power_on, power_off, card_in, key_one, key_ten, key_start, key_cancel,
    output state, work, hold_in, mode, amount, remaining, charging, done_pulse
  );
endinterface

// File: rtl/charge_session_ctrl.sv
// Charging-pile session sequencer: OFF -> READY -> SELECT -> CHARGE -> DONE, 1 s tick prescaler.
// Optional SELECT inactivity timeout enabled by defining SELECT_TIMEOUT_EN.
module charge_session_ctrl #(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned SEC_PER_UNIT = 3,
  parameter int unsigned MAX_AMOUNT   = 20,
  parameter int unsigned DONE_SEC     = 2,
  parameter int unsigned TIMEOUT_SEC  = 10
) (
  input  logic            clk,
  input  logic            reset,
  charge_session_if.slave bus
);
  typedef enum logic [2:0] {
    S_OFF    = 3'b000,
    S_READY  = 3'b001,
    S_SELECT = 3'b010,
    S_CHARGE = 3'b011,
    S_DONE   = 3'b100
  } state_e;

  localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SEC_MAX = (TIMEOUT_SEC > DONE_SEC) ? TIMEOUT_SEC : DONE_SEC;
  localparam int unsigned SW      = (SEC_MAX > 1) ? $clog2(SEC_MAX + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] DONE_LAST  = SW'(DONE_SEC - 1);
`ifdef SELECT_TIMEOUT_EN
  localparam logic [SW-1:0] TO_LAST    = SW'(TIMEOUT_SEC - 1);
`endif

  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic one, input logic ten);
    logic [5:0] sum;
    sum = {1'b0, a} + (one ? 6'd1 : 6'd0) + (ten ? 6'd10 : 6'd0);
    return (sum > 6'(MAX_AMOUNT)) ? 5'(MAX_AMOUNT) : sum[4:0];
  endfunction

  function automatic logic [7:0] charge_secs(input logic [4:0] a);
    return 8'(16'(a) * 16'(SEC_PER_UNIT));
  endfunction

  state_e        state_q, state_d;
  logic [4:0]    amount_q, amount_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          work_q, hold_in_q, charging_q, done_pulse_q;
  logic          tick, presc_run, key_clr;

  always_comb begin
    state_d     = state_q;
    amount_d    = amount_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    sec_d       = sec_q;
    presc_d     = '0;
    presc_run   = 1'b0;
    key_clr     = 1'b0;
    tick        = (presc_q == PRESC_LAST);

    case (state_q)
      S_OFF: begin
        if (bus.power_on) state_d = S_READY;
      end
      S_READY: begin
        if (bus.card_in) begin
          state_d  = S_SELECT;
          amount_d = '0;
          mode_d   = 2'b00;
        end
      end
      S_SELECT: begin
        if (bus.key_cancel) begin
          state_d  = S_READY;
          amount_d = '0;
          mode_d   = 2'b00;
        end else if (bus.key_start && (amount_q != '0)) begin
          state_d     = S_CHARGE;
          remaining_d = charge_secs(amount_q);
        end else if (bus.key_one || bus.key_ten) begin
          amount_d = sat_add(amount_q, bus.key_one, bus.key_ten);
          mode_d   = bus.key_ten ? 2'b10 : 2'b01;
        end
`ifdef SELECT_TIMEOUT_EN
        presc_run = 1'b1;
        // Any add/start activity restarts the inactivity window.
        if (bus.key_one || bus.key_ten || bus.key_start) begin
          key_clr = 1'b1;
        end else if (tick) begin
          if (sec_q == TO_LAST) begin
            state_d  = S_READY;
            amount_d = '0;
            mode_d   = 2'b00;
          end else begin
            sec_d = sec_q + SW'(1);
          end
        end
`endif
      end
      S_CHARGE: begin
        presc_run = 1'b1;
        if (bus.key_cancel) begin
          state_d = S_DONE;
        end else if (tick) begin
          if (remaining_q <= 8'd1) begin
            remaining_d = '0;
            state_d     = S_DONE;
          end else begin
            remaining_d = remaining_q - 8'd1;
          end
        end
      end
      S_DONE: begin
        presc_run = 1'b1;
        if (bus.key_cancel || (tick && (sec_q == DONE_LAST))) begin
          state_d     = S_READY;
          amount_d    = '0;
          remaining_d = '0;
          mode_d      = 2'b00;
        end else if (tick) begin
          sec_d = sec_q + SW'(1);
        end
      end
      default: state_d = S_OFF;
    endcase

    if (bus.power_off) begin
      state_d     = S_OFF;
      amount_d    = '0;
      remaining_d = '0;
      mode_d      = 2'b00;
    end

    // Prescaler and second counter restart on every state change.
    if ((state_d != state_q) || key_clr) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (presc_run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_OFF;
      amount_q     <= '0;
      remaining_q  <= '0;
      mode_q       <= 2'b00;
      presc_q      <= '0;
      sec_q        <= '0;
      work_q       <= 1'b0;
      hold_in_q    <= 1'b0;
      charging_q   <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      amount_q     <= amount_d;
      remaining_q  <= remaining_d;
      mode_q       <= mode_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      work_q       <= (state_d != S_OFF);
      hold_in_q    <= (state_d == S_SELECT) || (state_d == S_CHARGE) || (state_d == S_DONE);
      charging_q   <= (state_d == S_CHARGE);
      done_pulse_q <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign bus.state      = state_q;
  assign bus.work       = work_q;
  assign bus.hold_in    = hold_in_q;
  assign bus.mode       = mode_q;
  assign bus.amount     = amount_q;
  assign bus.remaining  = remaining_q;
  assign bus.charging   = charging_q;
  assign bus.done_pulse = done_pulse_q;
endmodule

// File: tb/tb_charge_session_ctrl.sv
// Bench for charge_session_ctrl: directed scenarios with literal expectations plus
// randomized panel pulses compared every cycle against a behavioural session model.
module tb_charge_session_ctrl;
  localparam int TICK_DIV     = 4;
  localparam int SEC_PER_UNIT = 3;
  localparam int MAX_AMOUNT   = 20;
  localparam int DONE_SEC     = 2;
  localparam int TIMEOUT_SEC  = 10;

  // Input vector layout: {power_on, power_off, card_in, key_one, key_ten, key_start, key_cancel}
  localparam logic [6:0] P_ON  = 7'b1000000;
  localparam logic [6:0] P_OFF = 7'b0100000;
  localparam logic [6:0] CARD  = 7'b0010000;
  localparam logic [6:0] K1    = 7'b0001000;
  localparam logic [6:0] K10   = 7'b0000100;
  localparam logic [6:0] KST   = 7'b0000010;
  localparam logic [6:0] KCAN  = 7'b0000001;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  charge_session_if sif();

  charge_session_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .SEC_PER_UNIT(SEC_PER_UNIT),
    .MAX_AMOUNT  (MAX_AMOUNT),
    .DONE_SEC    (DONE_SEC),
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  // Behavioural model: state number, purchase, seconds left, last-key mode,
  // and cycles elapsed since the current timing window opened.
  int m_state = 0;
  int m_amount = 0;
  int m_rem = 0;
  int m_mode = 0;
  int m_cyc = 0;
  bit m_dp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int ns;
    bit clr_cyc;
    bit on, off, card, k1, k10, st, can;
    bit tick;
    on   = sif.power_on;
    off  = sif.power_off;
    card = sif.card_in;
    k1   = sif.key_one;
    k10  = sif.key_ten;
    st   = sif.key_start;
    can  = sif.key_cancel;
    ns      = m_state;
    clr_cyc = 1'b0;
    tick    = ((m_cyc + 1) % TICK_DIV) == 0;
    case (m_state)
      0: if (on) ns = 1;
      1: if (card) begin ns = 2; m_amount = 0; m_mode = 0; end
      2: begin
        if (can) begin
          ns = 1; m_amount = 0; m_mode = 0;
        end else if (st && m_amount > 0) begin
          ns = 3; m_rem = m_amount * SEC_PER_UNIT;
        end else if (k1 || k10) begin
          m_amount = m_amount + (k1 ? 1 : 0) + (k10 ? 10 : 0);
          if (m_amount > MAX_AMOUNT) m_amount = MAX_AMOUNT;
          m_mode = k10 ? 2 : 1;
        end
`ifdef SELECT_TIMEOUT_EN
        if (k1 || k10 || st) clr_cyc = 1'b1;
        else if (m_cyc + 1 == TIMEOUT_SEC * TICK_DIV) begin
          ns = 1; m_amount = 0; m_mode = 0;
        end
`endif
      end
      3: begin
        if (can) ns = 4;
        else if (tick) begin
          m_rem--;
          if (m_rem == 0) ns = 4;
        end
      end
      4: if (can || (m_cyc + 1 == DONE_SEC * TICK_DIV)) begin
        ns = 1; m_amount = 0; m_rem = 0; m_mode = 0;
      end
      default: ns = 0;
    endcase
    if (off) begin ns = 0; m_amount = 0; m_rem = 0; m_mode = 0; end
    m_dp = (ns == 4) && (m_state != 4);
    if (ns != m_state || clr_cyc) m_cyc = 0;
    else m_cyc++;
    m_state = ns;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_amount = 0; m_rem = 0; m_mode = 0; m_cyc = 0; m_dp = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, half a cycle after each active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp.state",      32'(sif.state),      32'(m_state));
      check("cmp.amount",     32'(sif.amount),     32'(m_amount));
      check("cmp.remaining",  32'(sif.remaining),  32'(m_rem));
      check("cmp.mode",       32'(sif.mode),       32'(m_mode));
      check("cmp.work",       32'(sif.work),       32'(m_state != 0));
      check("cmp.hold_in",    32'(sif.hold_in),    32'(m_state >= 2));
      check("cmp.charging",   32'(sif.charging),   32'(m_state == 3));
      check("cmp.done_pulse", 32'(sif.done_pulse), 32'(m_dp));
    end
  end

  task automatic set_in(input logic [6:0] v);
    {sif.power_on, sif.power_off, sif.card_in, sif.key_one,
     sif.key_ten, sif.key_start, sif.key_cancel} = v;
  endtask

  task automatic pulse(input logic [6:0] v);
    set_in(v);
    @(negedge clk);
    set_in(7'b0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int st, input int am, input int md,
                     input int rm, input int dp);
    check({tag, ".state"},      32'(sif.state),      32'(st));
    check({tag, ".amount"},     32'(sif.amount),     32'(am));
    check({tag, ".mode"},       32'(sif.mode),       32'(md));
    check({tag, ".remaining"},  32'(sif.remaining),  32'(rm));
    check({tag, ".done_pulse"}, 32'(sif.done_pulse), 32'(dp));
    check({tag, ".work"},       32'(sif.work),       32'(st != 0));
    check({tag, ".hold_in"},    32'(sif.hold_in),    32'(st >= 2));
    check({tag, ".charging"},   32'(sif.charging),   32'(st == 3));
  endtask

  initial begin
    set_in(7'b0);
    wait_n(2);
    chk_en = 1'b1;
    chk("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    wait_n(1);

    // Session setup and accumulation.
    pulse(P_ON);
    chk("t1_on", 1, 0, 0, 0, 0);
    pulse(CARD);
    chk("t1_card", 2, 0, 0, 0, 0);
    pulse(K10);
    pulse(K1);
    pulse(K1);
    chk("t1_acc", 2, 12, 1, 0, 0);
    check("t1_model_amount", 32'(m_amount), 32'd12);

    // Cancel, ignored zero-amount start, cancel at amount 5.
    pulse(KCAN);
    chk("t4_cancel12", 1, 0, 0, 0, 0);
    pulse(CARD);
    pulse(KST);
    chk("t4_start0", 2, 0, 0, 0, 0);
    repeat (5) pulse(K1);
    chk("t4_amt5", 2, 5, 1, 0, 0);
    pulse(KCAN);
    chk("t4_cancel5", 1, 0, 0, 0, 0);

    // Saturation and mode tracking.
    pulse(CARD);
    repeat (3) pulse(K10);
    chk("t3_sat", 2, 20, 2, 0, 0);
    pulse(K1);
    chk("t3_one", 2, 20, 1, 0, 0);
    pulse(K1 | K10);
    chk("t3_both", 2, 20, 2, 0, 0);
    pulse(KCAN);

    // Full charge cycle; start together with an add uses the pre-add amount.
    pulse(CARD);
    pulse(K1);
    pulse(K1);
    pulse(KST | K10);
    chk("t2_start", 3, 2, 1, 6, 0);
    wait_n(3);
    check("t2_rem_e3", 32'(sif.remaining), 32'd6);
    wait_n(1);
    check("t2_rem_e4", 32'(sif.remaining), 32'd5);
    wait_n(19);
    chk("t2_e23", 3, 2, 1, 1, 0);
    wait_n(1);
    chk("t2_done", 4, 2, 1, 0, 1);
    wait_n(1);
    chk("t2_done1", 4, 2, 1, 0, 0);
    wait_n(6);
    check("t2_e31_state", 32'(sif.state), 32'd4);
    wait_n(1);
    chk("t2_ready", 1, 0, 0, 0, 0);

    // Cancel mid-charge freezes remaining; power_off clears everything.
    pulse(CARD);
    pulse(K1);
    pulse(K1);
    pulse(KST);
    wait_n(8);
    check("t5_rem4", 32'(sif.remaining), 32'd4);
    pulse(KCAN);
    chk("t5_cancel", 4, 2, 1, 4, 1);
    wait_n(1);
    chk("t5_hold", 4, 2, 1, 4, 0);
    pulse(P_OFF);
    chk("t5_off", 0, 0, 0, 0, 0);

    // SELECT inactivity.
    pulse(P_ON);
    pulse(CARD);
    wait_n(39);
    check("to_39", 32'(sif.state), 32'd2);
    wait_n(1);
`ifdef SELECT_TIMEOUT_EN
    check("to_40", 32'(sif.state), 32'd1);
`else
    check("to_40", 32'(sif.state), 32'd2);
`endif
    pulse(KCAN);
    check("to_ready", 32'(sif.state), 32'd1);

    // Asynchronous reset between edges during CHARGE.
    pulse(CARD);
    pulse(K1);
    pulse(KST);
    wait_n(2);
    #1 reset = 1'b1;
    #1 chk("t6_async", 0, 0, 0, 0, 0);
    wait_n(2);
    reset = 1'b0;
    wait_n(1);
    chk("t6_after", 0, 0, 0, 0, 0);

    // Randomized panel activity.
    for (int i = 0; i < 6000; i++) begin
      logic [6:0] v;
      v = 7'b0;
      if ($urandom_range(0, 499) == 0) v[5] = 1'b1;
      if ($urandom_range(0, 7) == 0)   v[6] = 1'b1;
      if ($urandom_range(0, 7) == 0)   v[4] = 1'b1;
      if ($urandom_range(0, 5) == 0)   v[3] = 1'b1;
      if ($urandom_range(0, 7) == 0)   v[2] = 1'b1;
      if ($urandom_range(0, 9) == 0)   v[1] = 1'b1;
      if ($urandom_range(0, 149) == 0) v[0] = 1'b1;
      set_in(v);
      @(negedge clk);
    end
    set_in(7'b0);
    wait_n(2);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
